// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Imported by the byte packer and the loader top.
package boot_pkg;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        LOAD = 3'd1,
        CSUM = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } boot_state_e;

    localparam int          BYTES_PER_WORD    = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/imem_boot_loader_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_vld pulses with the 4th byte.
// Latency 0 (word is combinational on the 4th byte); no backpressure of its own, upstream gates byte_vld.
module byte_word_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sh_q, sh_d;

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (byte_vld) begin
            cnt_d = cnt_q + 2'd1;
            // Shift right so the first byte of a word lands in the low lane.
            sh_d  = {byte_dat, sh_q[23:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            sh_q  <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

    assign word_vld = byte_vld && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_dat = {byte_dat, sh_q};

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed, checksummed program image into instruction memory, then releases core reset.
// Latency: 1 cycle from a word's 4th byte to im_we / status update; in_ready drops once DONE or ERR is reached.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_err
);

    localparam int IDXW = $clog2(DEPTH_WORDS) + 1;
    localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);

    boot_state_e     state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [31:0]     n_q, n_d;
    logic [31:0]     acc_q, acc_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            rdy_q, rdy_d;

    logic        word_vld;
    logic [31:0] word_dat;

    byte_word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .byte_vld (in_valid && rdy_q),
        .byte_dat (in_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            HDR: if (word_vld) begin
                n_d = word_dat;
                // Full 32-bit compare so huge lengths are rejected rather than wrapped.
                if (word_dat > 32'(DEPTH_WORDS)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (word_dat == 32'd0) begin
                    state_d = CSUM;
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: if (word_vld) begin
                we_d    = 1'b1;
                wdata_d = word_dat;
                addr_d  = BASE_ADDR + (32'(idx_q) << 2);
                acc_d   = acc_q + word_dat;
                idx_d   = idx_q + IDX_ONE;
                if (32'(idx_q) + 32'd1 == n_q) state_d = CSUM;
            end
            CSUM: if (word_vld) begin
                if (word_dat == acc_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            default: ;
        endcase
        rdy_d = (state_d == HDR) || (state_d == LOAD) || (state_d == CSUM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HDR;
            idx_q   <= '0;
            n_q     <= 32'd0;
            acc_q   <= 32'd0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign im_we     = we_q;
    assign im_addr   = addr_q;
    assign im_wdata  = wdata_q;
    assign core_rst  = ~done_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: nominal, bad checksum, overflow, empty, stalled and mid-load reset images.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        core_rst;
    logic        load_done;
    logic        load_err;

    int nvec = 0;
    int nerr = 0;
    bit gaps = 1'b0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always #5 clk = ~clk;

    imem_boot_loader #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .core_rst  (core_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always @(negedge clk) begin
        if (im_we) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        if (gaps) begin
            int k = $urandom_range(0, 5);
            in_valid = 1'b0;
            in_data  = 8'hA5;
            repeat (k) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        rst = 1'b0;
    endtask

    task automatic chk_final(input string tag, input bit done, input int nwr);
        chk({tag, "_done"},     32'(load_done), 32'(done));
        chk({tag, "_err"},      32'(load_err),  32'(!done));
        chk({tag, "_core_rst"}, 32'(core_rst),  32'(!done));
        chk({tag, "_ready"},    32'(in_ready),  32'd0);
        chk({tag, "_nwr"},      32'(wr_addr.size()), 32'(nwr));
    endtask

    task automatic nominal(input string tag, input logic [31:0] csum, input bit done);
        send_word(32'd2);
        send_word(32'h1111_2222);
        send_word(32'h0000_0003);
        chk({tag, "_pre_done"}, 32'(load_done), 32'd0);
        send_word(csum);
        chk_final(tag, done, 2);
        if (wr_addr.size() == 2) begin
            chk({tag, "_a0"}, wr_addr[0], 32'h0);
            chk({tag, "_d0"}, wr_data[0], 32'h1111_2222);
            chk({tag, "_a1"}, wr_addr[1], 32'h4);
            chk({tag, "_d1"}, wr_data[1], 32'h0000_0003);
        end
        idle();
        chk({tag, "_nwr_later"}, 32'(wr_addr.size()), 32'd2);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_we",    32'(im_we),     32'd0);
        chk("rst_addr",  im_addr,        32'h0);
        chk("rst_wdata", im_wdata,       32'h0);
        chk("rst_core",  32'(core_rst),  32'd1);
        chk("rst_done",  32'(load_done), 32'd0);
        chk("rst_err",   32'(load_err),  32'd0);
        chk("rst_ready", 32'(in_ready),  32'd0);
        rst = 1'b0;
        chk("ready_low_at_release", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("ready_rises", 32'(in_ready), 32'd1);

        nominal("nom", 32'h1111_2225, 1'b1);

        do_reset();
        nominal("badcs", 32'h1111_2226, 1'b0);

        do_reset();
        send_word(32'd5);
        chk_final("ovf", 1'b0, 0);
        idle();
        chk("ovf_nwr_later", 32'(wr_addr.size()), 32'd0);

        do_reset();
        send_word(32'hFFFF_FFFF);
        chk_final("nmax", 1'b0, 0);

        do_reset();
        send_word(32'd0);
        send_word(32'd0);
        chk_final("empty_ok", 1'b1, 0);

        do_reset();
        send_word(32'd0);
        send_word(32'd1);
        chk_final("empty_bad", 1'b0, 0);

        do_reset();
        gaps = 1'b1;
        nominal("stall", 32'h1111_2225, 1'b1);
        gaps = 1'b0;

        do_reset();
        send_word(32'd2);
        send_byte(8'h22);
        send_byte(8'h22);
        do_reset();
        chk("mid_rst_done", 32'(load_done), 32'd0);
        send_word(32'd1);
        send_word(32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF);
        chk_final("restart", 1'b1, 1);
        if (wr_addr.size() == 1) begin
            chk("restart_a0", wr_addr[0], 32'h0);
            chk("restart_d0", wr_data[0], 32'hDEAD_BEEF);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
